// File: rtl/a2d_pkg.sv
`default_nettype none
// ============================================================================
// Module   : a2d_pkg
// Brief    : Shared types and constants for the A2D SPI responder model.
// Revision : 1.0 - initial release
// ============================================================================
package a2d_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } resp_state_t;

    localparam int FRAME_BITS = 16;
    localparam int SHFT_W     = 16;
    localparam int CHNL_MSB   = 13;
    localparam int CHNL_LSB   = 11;

    localparam logic [2:0] CH_LP  = 3'd0;
    localparam logic [2:0] CH_B1  = 3'd1;
    localparam logic [2:0] CH_B2  = 3'd2;
    localparam logic [2:0] CH_B3  = 3'd3;
    localparam logic [2:0] CH_HP  = 3'd4;
    localparam logic [2:0] CH_VOL = 3'd7;

    // Bit counter sticks at all-ones so over-long frames stay distinguishable.
    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_edge_sync
// Brief    : Multi-flop synchronizer with rise/fall detect on the synced level.
// Revision : 1.0 - initial release
// ============================================================================
module spi_edge_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= (r_sync << 1) | STAGES'(i_din);
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  =  r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] &  r_prev;

endmodule
`default_nettype wire

// File: rtl/a2d_spi_resp.sv
`default_nettype none
// ============================================================================
// Module   : a2d_spi_resp
// Brief    : SPI responder emulating the A2D: returns the previous command's
//            channel conversion while receiving the next command.
// Revision : 1.0 - initial release
// ============================================================================
module a2d_spi_resp
    import a2d_pkg::*;
#(
    parameter int NCH         = 8,
    parameter int DW          = 12,
    parameter int FRAME_BITS  = a2d_pkg::FRAME_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SCLK,
    input  logic              MOSI,
    input  logic              a2d_SS_n,
    input  logic [NCH*DW-1:0] ch_vals,
    output logic              MISO,
    output logic [2:0]        cmd_chnnl,
    output logic              cmd_vld,
    output logic              frame_err
);

    localparam logic [4:0] c_FRAME_CNT = 5'(FRAME_BITS);

    logic                   w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic                   w_ss_lvl, w_ss_rise, w_ss_fall;
    logic                   w_mosi;
    logic [2:0]             w_ch;

    logic [SYNC_STAGES-1:0] r_mosi_sync;
    resp_state_t            r_state;
    logic [SHFT_W-1:0]      r_tx;
    logic [CHNL_MSB:0]      r_rx;
    logic [4:0]             r_bit_cnt;
    logic [DW-1:0]          r_result;
    logic [2:0]             r_chnnl;
    logic                   r_vld;
    logic                   r_err;

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk     (clk),
        .rst     (rst),
        .i_din   (SCLK),
        .o_level (w_sclk_lvl),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    // Reset-low chain: SS_n held low through reset never looks like a fall.
    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ss_sync (
        .clk     (clk),
        .rst     (rst),
        .i_din   (a2d_SS_n),
        .o_level (w_ss_lvl),
        .o_rise  (w_ss_rise),
        .o_fall  (w_ss_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) r_mosi_sync <= '0;
        else     r_mosi_sync <= (r_mosi_sync << 1) | SYNC_STAGES'(MOSI);
    end

    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
    assign w_ch   = r_rx[CHNL_MSB:CHNL_LSB];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_tx      <= '0;
            r_rx      <= '0;
            r_bit_cnt <= '0;
            r_result  <= '0;
            r_chnnl   <= '0;
            r_vld     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Mode 0: a frame opens with SCLK at its idle-low level.
                    if (w_ss_fall && !w_sclk_lvl) begin
                        r_tx      <= SHFT_W'(r_result);
                        r_bit_cnt <= '0;
                        r_state   <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (w_ss_rise) begin
                        r_state <= DONE;
                    end else begin
                        if (w_sclk_rise) begin
                            r_rx      <= {r_rx[CHNL_MSB-1:0], w_mosi};
                            r_bit_cnt <= sat_inc(r_bit_cnt);
                        end
                        if (w_sclk_fall && (r_bit_cnt < c_FRAME_CNT)) begin
                            r_tx <= r_tx << 1;
                        end
                    end
                end
                DONE: begin
                    if (r_bit_cnt == c_FRAME_CNT) begin
                        r_chnnl  <= w_ch;
                        r_result <= ch_vals[w_ch*DW +: DW];
                        r_vld    <= 1'b1;
                    end else begin
                        r_err <= 1'b1;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign MISO      = (r_state == ACTIVE) && !w_ss_lvl && r_tx[SHFT_W-1];
    assign cmd_chnnl = r_chnnl;
    assign cmd_vld   = r_vld;
    assign frame_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_a2d_spi_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_a2d_spi_resp
// Brief    : Directed SPI master with scoreboard for the A2D responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_a2d_spi_resp;

    localparam int HALF   = 6;
    localparam int EV_NONE = 0;
    localparam int EV_VLD  = 1;
    localparam int EV_ERR  = 2;

    typedef struct packed {
        logic [16:0] word;
        logic [5:0]  nbits;
        logic        skip;
    } miso_exp_t;

    typedef struct packed {
        logic       err;
        logic [2:0] ch;
    } ev_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        SCLK = 1'b0;
    logic        MOSI = 1'b0;
    logic        a2d_SS_n = 1'b1;
    logic [95:0] ch_vals;
    logic        MISO;
    logic [2:0]  cmd_chnnl;
    logic        cmd_vld;
    logic        frame_err;

    logic [11:0] vals [8];
    miso_exp_t   mq [$];
    ev_exp_t     eq [$];
    int          checks = 0;
    int          errors = 0;

    logic        mon_sclk_q = 1'b0;
    logic        mon_ss_q = 1'b1;
    int          mon_cnt = 0;
    logic [31:0] mon_cap = '0;
    miso_exp_t   mon_m;
    ev_exp_t     mon_e;

    always #5 clk = ~clk;

    always_comb begin
        ch_vals = '0;
        for (int n = 0; n < 8; n++) ch_vals[n*12 +: 12] = vals[n];
    end

    a2d_spi_resp dut (
        .clk       (clk),
        .rst       (rst),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .a2d_SS_n  (a2d_SS_n),
        .ch_vals   (ch_vals),
        .MISO      (MISO),
        .cmd_chnnl (cmd_chnnl),
        .cmd_vld   (cmd_vld),
        .frame_err (frame_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) tick();
    endtask

    // act: 0 plain, 1 change ch3 to 0xFFF at bit 8, 2 pulse rst at bit 8
    task automatic spi_frame(input logic [15:0] cmd, input int nbits, input int act);
        a2d_SS_n = 1'b0;
        wait_clks(HALF);
        for (int i = 0; i < nbits; i++) begin
            MOSI = (i < 16) ? cmd[15-i] : 1'b0;
            if (i == 8 && act == 1) vals[3] = 12'hFFF;
            if (i == 8 && act == 2) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            wait_clks(HALF);
            SCLK = 1'b1;
            wait_clks(HALF);
            SCLK = 1'b0;
        end
        wait_clks(HALF);
        a2d_SS_n = 1'b1;
        wait_clks(2*HALF);
    endtask

    task automatic frame(input logic [15:0] cmd, input int nbits, input logic [15:0] resp,
                         input int ev, input logic [2:0] ch, input int act);
        miso_exp_t m;
        ev_exp_t   e;
        m.nbits = 6'(nbits);
        m.skip  = (act == 2);
        m.word  = (nbits <= 16) ? 17'(resp >> (16 - nbits)) : {resp, resp[0]};
        mq.push_back(m);
        if (ev != EV_NONE) begin
            e.err = (ev == EV_ERR);
            e.ch  = ch;
            eq.push_back(e);
        end
        spi_frame(cmd, nbits, act);
    endtask

    // Monitor: pops expected events and MISO words as the DUT produces them.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && (cmd_vld || frame_err)) begin
                checks++;
                if (eq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got vld=%b err=%b ch=%0d, required none",
                             cmd_vld, frame_err, cmd_chnnl);
                end else begin
                    mon_e = eq.pop_front();
                    if (cmd_vld != !mon_e.err || frame_err != mon_e.err || cmd_chnnl != mon_e.ch) begin
                        errors++;
                        $display("FAIL event: got vld=%b err=%b ch=%0d, required vld=%b err=%b ch=%0d",
                                 cmd_vld, frame_err, cmd_chnnl, !mon_e.err, mon_e.err, mon_e.ch);
                    end
                end
            end
            if (!a2d_SS_n && SCLK && !mon_sclk_q) begin
                mon_cap = {mon_cap[30:0], MISO};
                mon_cnt++;
            end
            if (a2d_SS_n && !mon_ss_q) begin
                if (mq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL miso_queue: got frame of %0d bits, required none", mon_cnt);
                end else begin
                    mon_m = mq.pop_front();
                    if (!mon_m.skip) begin
                        checks++;
                        if (mon_cnt != int'(mon_m.nbits) || mon_cap != 32'(mon_m.word)) begin
                            errors++;
                            $display("FAIL miso_resp: got %0d bits 0x%0h, required %0d bits 0x%0h",
                                     mon_cnt, mon_cap, mon_m.nbits, mon_m.word);
                        end
                    end
                end
                mon_cnt = 0;
                mon_cap = '0;
            end
            mon_sclk_q = SCLK;
            mon_ss_q   = a2d_SS_n;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vals[0] = 12'hABC; vals[1] = 12'h222; vals[2] = 12'h333; vals[3] = 12'h444;
        vals[4] = 12'h555; vals[5] = 12'h666; vals[6] = 12'h0F0; vals[7] = 12'h777;
        wait_clks(4);
        @(negedge clk);
        checks++;
        if ({MISO, cmd_vld, frame_err, cmd_chnnl} != 6'd0) begin
            errors++;
            $display("FAIL reset_outputs: got 0x%0h, required 0x0", {MISO, cmd_vld, frame_err, cmd_chnnl});
        end
        tick();
        rst = 1'b0;
        wait_clks(8);

        frame(16'h0000, 16, 16'h0000, EV_VLD, 3'd0, 0);
        frame(16'h0800, 16, 16'h0ABC, EV_VLD, 3'd1, 0);
        vals[0] = 12'h111;
        frame(16'h0000, 16, 16'h0222, EV_VLD, 3'd0, 0);
        frame(16'h0800, 16, 16'h0111, EV_VLD, 3'd1, 0);
        frame(16'h1000, 16, 16'h0222, EV_VLD, 3'd2, 0);
        frame(16'h1800, 16, 16'h0333, EV_VLD, 3'd3, 0);
        frame(16'h2000, 16, 16'h0444, EV_VLD, 3'd4, 0);
        frame(16'h3800, 16, 16'h0555, EV_VLD, 3'd7, 0);
        frame(16'hC7FF, 16, 16'h0777, EV_VLD, 3'd0, 0);
        frame(16'h2800, 16, 16'h0111, EV_VLD, 3'd5, 0);
        frame(16'h1000,  9, 16'h0666, EV_ERR, 3'd5, 0);
        frame(16'h3000, 16, 16'h0666, EV_VLD, 3'd6, 0);
        frame(16'h0800, 17, 16'h00F0, EV_ERR, 3'd6, 0);
        vals[3] = 12'h123;
        frame(16'h1800, 16, 16'h00F0, EV_VLD, 3'd3, 0);
        frame(16'h2000, 16, 16'h0123, EV_VLD, 3'd4, 1);
        frame(16'h0800, 16, 16'h0000, EV_NONE, 3'd0, 2);
        @(negedge clk);
        checks++;
        if (cmd_chnnl != 3'd0) begin
            errors++;
            $display("FAIL post_reset_chnnl: got %0d, required 0", cmd_chnnl);
        end
        frame(16'h1000, 16, 16'h0000, EV_VLD, 3'd2, 0);
        frame(16'h0000, 16, 16'h0333, EV_VLD, 3'd0, 0);

        wait_clks(10);
        @(negedge clk);
        checks++;
        if (eq.size() != 0 || mq.size() != 0) begin
            errors++;
            $display("FAIL queues_drained: got ev=%0d miso=%0d, required 0 0", eq.size(), mq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/a2d_spi_resp.md
Name: a2d_spi_resp

Overview:
- SPI responder that emulates the slide-pot A2D converter at the far end of the A2D SPI link.
- Receives 16-bit command frames on MOSI and returns, in the following frame, the 12-bit conversion of the channel requested in the previous command on MISO.
- Used as the bench/FPGA-side model so the round-robin pot interface (LP, B1, B2, B3, HP, VOLUME on ch 0-4, 7) can be exercised end-to-end.
- Channel values come from a parallel input bus.

Parameters:
- NCH, 8, number of analog channels
- DW, 12, conversion result width
- FRAME_BITS, 16, SCLK rising edges per valid frame
- SYNC_STAGES, 2, metastability flops on SCLK/SS_n/MOSI before edge detect

Ports:
- clk  in  1  system clock
- rst  in  1  reset (synchronous, active-high)
- SCLK  in  1  SPI clock from master, idle low (mode 0)
- MOSI  in  1  master-out data, changes on SCLK fall
- a2d_SS_n  in  1  active-low slave select
- ch_vals  in  NCH*DW  channel n value at bits [n*DW +: DW]
- MISO  out  1  slave-out data, sampled by master on SCLK rise
- cmd_chnnl  out  3  channel of last valid command
- cmd_vld  out  1  one-cycle pulse when a valid command frame completes
- frame_err  out  1  one-cycle pulse when SS_n rises with bit count != FRAME_BITS

Behaviour:
- Reset values: all outputs 0; result_reg 0; bit_cnt 0; state IDLE.
  - Synchronizer chain for a2d_SS_n resets to 0 and SCLK chain to 0, so an SS_n held low through reset never produces a false frame start.
- Edges: SCLK rise/fall and SS_n fall/rise are detected on synced samples. Detection latency is SYNC_STAGES+1 clk.
  - MOSI is delayed by the same depth so it stays aligned with SCLK.
  - SCLK high and low phases must each be >= SYNC_STAGES+2 clk.
- States:
  - IDLE: wait for SS_n fall. On fall: tx_shft <= {(16-DW)'b0, result_reg}, bit_cnt <= 0, -> ACTIVE.
  - ACTIVE, on SCLK rise: rx_shft <= {rx_shft[14:0], MOSI_sync}; bit_cnt++ (5 bits, saturates at 31).
  - ACTIVE, on SCLK fall: tx_shft shifts left with 0 fill, but only while bit_cnt < FRAME_BITS. The fall that follows the 16th rise is ignored.
  - ACTIVE, on SS_n rise: -> DONE.
  - DONE (one cycle):
    - If bit_cnt == FRAME_BITS: cmd_chnnl <= rx_shft[13:11]; result_reg <= ch_vals[rx_shft[13:11]] (the conversion); cmd_vld = 1.
    - Otherwise: frame_err = 1; cmd_chnnl and result_reg unchanged.
    - Then -> IDLE.
- MISO = tx_shft[15] in ACTIVE, 0 otherwise. MISO is never high-Z.
- Command decode:
  - Only bits [13:11] are used.
  - Bits [15:14] and [10:0] are ignored, with no error.
  - All 8 channels are legal, including the unused 5 and 6.
- Result pipelining:
  - The frame N response carries the channel of the frame N-1 command.
  - The first frame after reset returns 0x0000.
- ch_vals is sampled only in DONE. Changes during a frame do not affect the data being shifted out.
- Simultaneous events:
  - An SS_n rise coincident with an SCLK edge is handled as SS_n rise only; that SCLK edge is discarded.
  - An SS_n fall while in DONE is not possible, because SS_n was just high.
- Reset asserted mid-frame aborts the frame. No cmd_vld or frame_err is produced. The block waits for a fresh SS_n fall.

Decomposition:
- Package a2d_pkg:
  - resp_state_t enum {IDLE, ACTIVE, DONE}
  - FRAME_BITS
  - CHNL_MSB=13, CHNL_LSB=11
  - channel constants CH_LP=0, CH_B1=1, CH_B2=2, CH_B3=3, CH_HP=4, CH_VOL=7
- Sub-module spi_edge_sync (SYNC_STAGES flops + edge detect; outputs level, rise, fall), instanced for SCLK and a2d_SS_n.

Test Plan:
- ch_vals ch0=0xABC; frame 1 cmd 0x0000, frame 2 cmd 0x0800 -> frame 1 MISO returns 0x0000, frame 2 returns 0x0ABC, cmd_vld pulses twice, cmd_chnnl=1 after frame 2.
- Round-robin ch 0,1,2,3,4,7,0 with distinct values (0x111..0x777) -> each response equals the previous frame's channel value; ch 7 response = 0x777.
- Abort after 9 SCLK rises (SS_n rises early) -> frame_err one-cycle pulse, no cmd_vld; next frame returns the same result_reg as before the abort.
- 17 SCLK rises in one frame -> frame_err, cmd_chnnl unchanged.
- Change ch_vals[ch3] from 0x123 to 0xFFF mid-frame after a ch3 command -> response is 0x0123 (the value latched at the command's DONE).
- Assert rst for 1 cycle at bit 8 while SS_n stays low; complete 16 SCLKs -> no cmd_vld or frame_err. The next full frame (new SS_n fall) returns 0x0000.
